// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: data-memory FSM encoding, word width, clog2 helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package y86_pkg;

  localparam int WORD_W = 64;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_t;

  // Ceiling log2 for elaboration-time sizing; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port DATA_W x DEPTH storage with synchronous write and synchronous read.
// Latency: read data registered one edge after en; read-during-write returns old data.
// Backpressure: none; access happens on every edge where en is high.
import y86_pkg::*;

module dmem_array #(
  parameter int DATA_W = WORD_W,
  parameter int DEPTH  = 8192,
  parameter int IDX_W  = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is intentionally not reset; rdata holds between enabled accesses.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[idx] <= wdata;
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/data_memory_hs.sv
// Y86-64 M-stage data memory with valid/ready request port and one-cycle response pulse.
// Latency: response in cycle T+1+WAIT_CYCLES after acceptance at edge T; array commits on the edge entering RESP.
// Backpressure: req_ready low only during WAIT; rsp_valid has no backpressure.
import y86_pkg::*;

module data_memory_hs #(
  parameter int DATA_W      = WORD_W,
  parameter int ADDR_W      = 64,
  parameter int DEPTH       = 8192,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              dmem_error
);

  localparam int OFS   = clog2(DATA_W / 8);
  localparam int IDX_W = clog2(DEPTH);
  localparam logic [ADDR_W-1:0] OFS_MASK = (ADDR_W'(1) << OFS) - ADDR_W'(1);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

  dmem_state_t       state;
  logic [3:0]        cnt;
  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              rdata_ok;

  logic              accept;
  logic              from_wait;
  logic              commit;
  logic              c_write;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_err;
  logic [DATA_W-1:0] arr_rdata;

  assign accept = req_valid && req_ready;

  // Select the request being committed: latched one leaving WAIT, or the live one for zero-wait.
  always_comb begin
    from_wait = (state == DMEM_WAIT) && (cnt == 4'd0);
    commit    = from_wait || (accept && (WAIT_CYCLES == 0));
    c_write   = from_wait ? lat_write : req_write;
    c_addr    = from_wait ? lat_addr  : req_addr;
    c_wdata   = from_wait ? lat_wdata : req_wdata;
    c_err     = ((c_addr & OFS_MASK) != '0) || ((c_addr >> OFS) >= DEPTH_A);
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .en    (commit && !c_err),
    .we    (c_write),
    .idx   (IDX_W'(c_addr >> OFS)),
    .wdata (c_wdata),
    .rdata (arr_rdata)
  );

  // Array read register is unreset, so gate it with a reset flop to give zero after reset/error/store.
  assign rsp_rdata = rdata_ok ? arr_rdata : '0;

  // Handshake FSM with wait counter and registered ready/valid/error outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= DMEM_IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      dmem_error <= 1'b0;
      rdata_ok   <= 1'b0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        DMEM_WAIT: begin
          if (cnt == 4'd0) begin
            state     <= DMEM_RESP;
            rsp_valid <= 1'b1;
            req_ready <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            if (WAIT_CYCLES > 0) begin
              state     <= DMEM_WAIT;
              cnt       <= 4'(WAIT_CYCLES - 1);
              req_ready <= 1'b0;
            end else begin
              state     <= DMEM_RESP;
              rsp_valid <= 1'b1;
              req_ready <= 1'b1;
            end
          end else begin
            state     <= DMEM_IDLE;
            req_ready <= 1'b1;
          end
        end
      endcase
      if (commit) begin
        dmem_error <= c_err;
        rdata_ok   <= !c_err && !c_write;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_hs.sv
// Self-checking bench: zero-wait and three-wait instances, table vectors plus handshake/reset sequences.
// Latency: response cycle checked against acceptance cycle via scoreboard.
// Backpressure: driver holds req_valid until req_ready is seen.
module tb_data_memory_hs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // zero-wait instance
  logic        rst0, v0, w0, rdy0, rv0, err0;
  logic [63:0] a0, d0, rd0;
  // three-wait instance
  logic        rst3, v3, w3, rdy3, rv3, err3;
  logic [63:0] a3, d3, rd3;

  data_memory_hs #(.DATA_W(64), .ADDR_W(64), .DEPTH(8192), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst0), .req_valid(v0), .req_ready(rdy0), .req_write(w0),
    .req_addr(a0), .req_wdata(d0), .rsp_valid(rv0), .rsp_rdata(rd0), .dmem_error(err0));

  data_memory_hs #(.DATA_W(64), .ADDR_W(64), .DEPTH(8192), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst3), .req_valid(v3), .req_ready(rdy3), .req_write(w3),
    .req_addr(a3), .req_wdata(d3), .rsp_valid(rv3), .rsp_rdata(rd3), .dmem_error(err3));

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        exp_err;
    logic [63:0] exp_rdata;
    logic        chk_data;
  } vec_t;

  typedef struct {
    logic        exp_err;
    logic [63:0] exp_rdata;
    logic        chk_data;
    int          exp_cyc;
  } sb_t;

  sb_t q0[$];
  sb_t q3[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard pop/compare for each response pulse.
  always @(negedge clk) begin
    sb_t e;
    if (rv0) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_rsp0: got rsp_valid=1 expected none (cycle %0d)", cyc);
      end else begin
        e = q0.pop_front();
        chk("rsp_cycle0", 64'(cyc), 64'(e.exp_cyc));
        chk("dmem_error0", 64'(err0), 64'(e.exp_err));
        if (e.chk_data) chk("rsp_rdata0", rd0, e.exp_rdata);
      end
    end
    if (rv3) begin
      if (q3.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_rsp3: got rsp_valid=1 expected none (cycle %0d)", cyc);
      end else begin
        e = q3.pop_front();
        chk("rsp_cycle3", 64'(cyc), 64'(e.exp_cyc));
        chk("dmem_error3", 64'(err3), 64'(e.exp_err));
        if (e.chk_data) chk("rsp_rdata3", rd3, e.exp_rdata);
      end
    end
  end

  // Drive a request at a negedge, hold it until accepted, push its expectation; returns at the next negedge.
  task automatic send(input int sel, input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                      input logic exp_err, input logic [63:0] exp_rd, input logic chk_d, input logic push);
    sb_t  e;
    int   n;
    logic rdy;
    if (sel == 0) begin v0 = 1'b1; w0 = wr; a0 = addr; d0 = wdata; end
    else          begin v3 = 1'b1; w3 = wr; a3 = addr; d3 = wdata; end
    n = 0;
    rdy = (sel == 0) ? rdy0 : rdy3;
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
      rdy = (sel == 0) ? rdy0 : rdy3;
    end
    if (!rdy) begin
      checks++; failures++;
      $display("FAIL accept_timeout%0d: got req_ready=0 expected 1 within 50 cycles", sel);
    end else begin
      e.exp_err   = exp_err;
      e.exp_rdata = exp_rd;
      e.chk_data  = chk_d;
      e.exp_cyc   = cyc + 1 + ((sel == 0) ? 0 : 3);
      @(posedge clk);
      if (push) begin
        if (sel == 0) q0.push_back(e);
        else          q3.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q3.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0 || q3.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0", q0.size(), q3.size());
    end
  endtask

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1'b1, 64'h40,    64'hDEADBEEF01234567, 1'b0, 64'h0,                1'b0};
    tbl[1]  = '{1'b0, 64'h40,    64'h0,                1'b0, 64'hDEADBEEF01234567, 1'b1};
    tbl[2]  = '{1'b1, 64'h43,    64'h1111,             1'b1, 64'h0,                1'b0};
    tbl[3]  = '{1'b0, 64'h40,    64'h0,                1'b0, 64'hDEADBEEF01234567, 1'b1};
    tbl[4]  = '{1'b0, 64'h10000, 64'h0,                1'b1, 64'h0,                1'b1};
    tbl[5]  = '{1'b0, 64'hFFF8,  64'h0,                1'b0, 64'h0,                1'b0};
    tbl[6]  = '{1'b1, 64'h8,     64'hA5,               1'b0, 64'h0,                1'b0};
    tbl[7]  = '{1'b0, 64'h8,     64'h0,                1'b0, 64'hA5,               1'b1};
    tbl[8]  = '{1'b1, 64'hFFF8,  64'h1234,             1'b0, 64'h0,                1'b0};
    tbl[9]  = '{1'b0, 64'hFFF8,  64'h0,                1'b0, 64'h1234,             1'b1};
    tbl[10] = '{1'b0, 64'h41,    64'h0,                1'b1, 64'h0,                1'b1};
    tbl[11] = '{1'b1, 64'h10000, 64'hBAD,              1'b1, 64'h0,                1'b0};
    tbl[12] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0,  1'b1, 64'h0,                1'b1};
    tbl[13] = '{1'b0, 64'h8,     64'h0,                1'b0, 64'hA5,               1'b1};

    rst0 = 1'b1; rst3 = 1'b1;
    v0 = 1'b0; w0 = 1'b0; a0 = '0; d0 = '0;
    v3 = 1'b0; w3 = 1'b0; a3 = '0; d3 = '0;
    repeat (3) @(negedge clk);
    rst0 = 1'b0; rst3 = 1'b0;
    @(negedge clk);

    // reset state
    chk("reset_ready0", 64'(rdy0), 64'd1);
    chk("reset_rsp_valid0", 64'(rv0), 64'd0);
    chk("reset_rdata0", rd0, 64'd0);
    chk("reset_error0", 64'(err0), 64'd0);
    chk("reset_ready3", 64'(rdy3), 64'd1);

    // zero-wait table, req_valid held high throughout (back-to-back)
    for (int i = 0; i < 14; i++)
      send(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_err, tbl[i].exp_rdata, tbl[i].chk_data, 1'b1);
    v0 = 1'b0;

    // idle inputs carrying a store must be ignored
    w0 = 1'b1; a0 = 64'h40; d0 = 64'h5555;
    repeat (4) @(negedge clk);
    send(0, 1'b0, 64'h40, 64'h0, 1'b0, 64'hDEADBEEF01234567, 1'b1, 1'b1);
    v0 = 1'b0;
    drain();

    // three-wait: seed contents
    send(3, 1'b1, 64'h18, 64'h55, 1'b0, 64'h0, 1'b0, 1'b1);
    send(3, 1'b0, 64'h18, 64'h0, 1'b0, 64'h55, 1'b1, 1'b1);
    v3 = 1'b0;
    drain();

    // ready low through WAIT, new request accepted in the RESP cycle
    send(3, 1'b0, 64'h18, 64'h0, 1'b0, 64'h55, 1'b1, 1'b1);
    v3 = 1'b0;
    chk("wait_ready_c1", 64'(rdy3), 64'd0);
    @(negedge clk);
    chk("wait_ready_c2", 64'(rdy3), 64'd0);
    @(negedge clk);
    chk("wait_ready_c3", 64'(rdy3), 64'd0);
    @(negedge clk);
    chk("resp_ready", 64'(rdy3), 64'd1);
    chk("resp_valid", 64'(rv3), 64'd1);
    send(3, 1'b1, 64'h20, 64'h99, 1'b0, 64'h0, 1'b0, 1'b1);
    send(3, 1'b0, 64'h20, 64'h0, 1'b0, 64'h99, 1'b1, 1'b1);
    v3 = 1'b0;
    drain();

    // async reset during WAIT of a store: nothing commits, no response follows
    send(3, 1'b1, 64'h18, 64'h77, 1'b0, 64'h0, 1'b0, 1'b0);
    v3 = 1'b0;
    #2 rst3 = 1'b1;
    #1;
    chk("midrst_rsp_valid", 64'(rv3), 64'd0);
    chk("midrst_rdata", rd3, 64'd0);
    chk("midrst_error", 64'(err3), 64'd0);
    chk("midrst_ready", 64'(rdy3), 64'd1);
    @(negedge clk);
    rst3 = 1'b0;
    repeat (8) @(negedge clk);
    send(3, 1'b0, 64'h18, 64'h0, 1'b0, 64'h55, 1'b1, 1'b1);
    v3 = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
